// File: rtl/pattern_tx_pkg.sv
// Shared types and constants for the bit-serial pattern transmitter.
// PATTERN_TX_PARITY_EN lengthens every frame by one even-parity bit.
package pattern_tx_pkg;

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    localparam logic [3:0] DEFAULT_PATTERN = 4'b1101;

`ifdef PATTERN_TX_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    function automatic int frame_len(input int pat_w);
        return pat_w + PARITY_BITS;
    endfunction

endpackage

// File: rtl/pattern_tx.sv
// Bit-serial pattern transmitter: sends a latched pattern MSB-first N times, then pulses done.
// Build option PATTERN_TX_PARITY_EN appends an even-parity bit to every frame.
module pattern_tx
    import pattern_tx_pkg::*;
#(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern_in,
    input  logic [CNT_W-1:0] repeat_cnt,
    input  logic             idle_val,
    output logic             dout,
    output logic             dout_valid,
    output logic             frame_start,
    output logic             busy,
    output logic             done,
    output state_t           dbg_state
);

    localparam int FRAME_LEN = frame_len(PAT_W);
    localparam int IDX_W     = $clog2(FRAME_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] ONE_FRAME = CNT_W'(1);

    state_t           r_state;
    logic [PAT_W-1:0] r_pat;
    logic [PAT_W-1:0] r_shift;
    logic [IDX_W-1:0] r_idx;
    logic [CNT_W-1:0] r_frames;
    logic             r_dout;
    logic             r_valid;
    logic             r_fs;
    logic             r_busy;
    logic             r_done;

    logic             w_next_bit;

    // r_idx tracks the bit currently on dout; r_shift holds the bits still to come.
    always_comb begin
        w_next_bit = r_shift[PAT_W-1];
`ifdef PATTERN_TX_PARITY_EN
        if (r_idx == IDX_W'(1)) begin
            w_next_bit = ^r_pat;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_pat    <= '0;
            r_shift  <= '0;
            r_idx    <= '0;
            r_frames <= '0;
            r_dout   <= 1'b0;
            r_valid  <= 1'b0;
            r_fs     <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_dout  <= idle_val;
                    r_valid <= 1'b0;
                    r_fs    <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    if (start) begin
                        if (repeat_cnt != '0) begin
                            r_pat    <= pattern_in;
                            r_frames <= repeat_cnt;
                            r_shift  <= {pattern_in[PAT_W-2:0], 1'b0};
                            r_idx    <= LAST_IDX;
                            r_dout   <= pattern_in[PAT_W-1];
                            r_valid  <= 1'b1;
                            r_fs     <= 1'b1;
                            r_busy   <= 1'b1;
                            r_state  <= SEND;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end
                    end
                end
                SEND: begin
                    if (r_idx == '0) begin
                        r_frames <= r_frames - 1'b1;
                        if (r_frames == ONE_FRAME) begin
                            r_dout  <= idle_val;
                            r_valid <= 1'b0;
                            r_fs    <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_idx   <= LAST_IDX;
                            r_shift <= {r_pat[PAT_W-2:0], 1'b0};
                            r_dout  <= r_pat[PAT_W-1];
                            r_fs    <= 1'b1;
                        end
                    end else begin
                        r_idx   <= r_idx - 1'b1;
                        r_shift <= {r_shift[PAT_W-2:0], 1'b0};
                        r_dout  <= w_next_bit;
                        r_fs    <= 1'b0;
                    end
                end
                DONE: begin
                    r_dout  <= idle_val;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign dout        = r_dout;
    assign dout_valid  = r_valid;
    assign frame_start = r_fs;
    assign busy        = r_busy;
    assign done        = r_done;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_pattern_tx.sv
// Self-checking bench for pattern_tx: directed and random transmissions against a bit-list model.
module tb_pattern_tx;
    import pattern_tx_pkg::*;

    localparam int PAT_W = 4;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [PAT_W-1:0] pattern_in;
    logic [CNT_W-1:0] repeat_cnt;
    logic             idle_val;
    logic             dout;
    logic             dout_valid;
    logic             frame_start;
    logic             busy;
    logic             done;
    state_t           dbg_state;

    int checks = 0;
    int errors = 0;

    logic exp_q[$];
    logic exp_fs_q[$];
    logic exp_all[$];
    logic obs_all[$];

    pattern_tx #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pattern_in (pattern_in),
        .repeat_cnt (repeat_cnt),
        .idle_val   (idle_val),
        .dout       (dout),
        .dout_valid (dout_valid),
        .frame_start(frame_start),
        .busy       (busy),
        .done       (done),
        .dbg_state  (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Reference model: a transmission is the pattern MSB-first, cnt times, plus parity when enabled.
    task automatic build_model(input logic [PAT_W-1:0] pat, input int cnt);
        exp_q.delete();
        exp_fs_q.delete();
        for (int f = 0; f < cnt; f++) begin
            for (int b = PAT_W - 1; b >= 0; b--) begin
                exp_q.push_back(pat[b]);
                exp_fs_q.push_back(b == PAT_W - 1);
            end
`ifdef PATTERN_TX_PARITY_EN
            exp_q.push_back(^pat);
            exp_fs_q.push_back(1'b0);
`endif
        end
        exp_all = exp_q;
    endtask

    // Drives one start, checks every cycle of the transmission, the done pulse and the return to idle.
    task automatic send(input logic [PAT_W-1:0] pat, input int cnt, input logic iv, input logic poke);
        int nbits;
        int obs_hits;
        int exp_hits;
        build_model(pat, cnt);
        obs_all.delete();
        nbits      = exp_q.size();
        start      = 1'b1;
        pattern_in = pat;
        repeat_cnt = CNT_W'(cnt);
        idle_val   = iv;
        step();
        start      = 1'b0;
        pattern_in = PAT_W'($urandom);
        repeat_cnt = CNT_W'($urandom);
        for (int i = 0; i < nbits; i++) begin
            if (poke && i == 1) begin
                start      = 1'b1;
                pattern_in = ~pat;
                repeat_cnt = 8'd5;
            end
            check("valid", dout_valid, 1'b1);
            check("dout", dout, exp_q.pop_front());
            check("frame_start", frame_start, exp_fs_q.pop_front());
            check("busy", busy, 1'b1);
            check("done_early", done, 1'b0);
            obs_all.push_back(dout);
            step();
        end
        check("done_pulse", done, 1'b1);
        check("done_busy", busy, 1'b0);
        check("done_valid", dout_valid, 1'b0);
        check("done_dout", dout, iv);
        check("done_fs", frame_start, 1'b0);
        start = 1'b0;
        step();
        check("post_done", done, 1'b0);
        check("post_valid", dout_valid, 1'b0);
        check("post_dout", dout, iv);
        check("post_busy", busy, 1'b0);
        step();
        check("no_retx_valid", dout_valid, 1'b0);
        check("no_retx_done", done, 1'b0);
        obs_hits = 0;
        exp_hits = 0;
        for (int i = 0; i + 3 < obs_all.size(); i++) begin
            if ({obs_all[i], obs_all[i+1], obs_all[i+2], obs_all[i+3]} == 4'b1101) obs_hits++;
        end
        for (int i = 0; i + 3 < exp_all.size(); i++) begin
            if ({exp_all[i], exp_all[i+1], exp_all[i+2], exp_all[i+3]} == 4'b1101) exp_hits++;
        end
        check("detector_hits", obs_hits == exp_hits, 1'b1);
    endtask

    // Reset lands while the third bit of the first frame is on the line.
    task automatic reset_mid(input logic [PAT_W-1:0] pat, input logic iv);
        build_model(pat, 2);
        start      = 1'b1;
        pattern_in = pat;
        repeat_cnt = 8'd2;
        idle_val   = iv;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("rst_pre_valid", dout_valid, 1'b1);
            check("rst_pre_dout", dout, exp_q.pop_front());
            if (i < 2) step();
        end
        rst   = 1'b1;
        start = 1'b1;
        step();
        check("rst_dout", dout, 1'b0);
        check("rst_valid", dout_valid, 1'b0);
        check("rst_fs", frame_start, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_state", dbg_state == IDLE, 1'b1);
        rst   = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_after_done", done, 1'b0);
            check("rst_after_valid", dout_valid, 1'b0);
            check("rst_after_dout", dout, iv);
        end
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        pattern_in = '0;
        repeat_cnt = '0;
        idle_val   = 1'b0;
        step();
        start = 1'b1;
        step();
        check("reset_dout", dout, 1'b0);
        check("reset_valid", dout_valid, 1'b0);
        check("reset_fs", frame_start, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_state", dbg_state == IDLE, 1'b1);
        rst      = 1'b0;
        start    = 1'b0;
        idle_val = 1'b1;
        step();
        check("idle_dout", dout, 1'b1);
        step();

        send(DEFAULT_PATTERN, 1, 1'b0, 1'b0);
        send(DEFAULT_PATTERN, 3, 1'b0, 1'b0);
        send(PAT_W'($urandom), 0, 1'b1, 1'b0);
        send(DEFAULT_PATTERN, 2, 1'b0, 1'b1);
        reset_mid(DEFAULT_PATTERN, 1'b0);
        send(DEFAULT_PATTERN, 1, 1'b1, 1'b0);
        send(DEFAULT_PATTERN, 2, 1'b1, 1'b0);
        for (int r = 0; r < 8; r++) begin
            send(PAT_W'($urandom), $urandom_range(1, 6), 1'($urandom), 1'($urandom_range(0, 1)));
        end
        send(PAT_W'($urandom), 255, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
